// File: rtl/alsu_arbiter_if.sv
// alsu_arbiter_if: bundles the requester, ALSU and response signals of
// alsu_arbiter.
//   req0_*/req1_* : command channels (valid/ready/16-bit cmd)
//   alsu_*        : command fields driven to the shared ALSU, alsu_out result
//   resp_*        : response channel (valid/ready, data, requester id, invalid)
// slave  = arbiter view, master = surrounding fabric/ALSU view.
interface alsu_arbiter_if;
  logic        req0_valid, req0_ready;
  logic [15:0] req0_cmd;
  logic        req1_valid, req1_ready;
  logic [15:0] req1_cmd;

  logic [2:0]  alsu_opcode, alsu_A, alsu_B;
  logic        alsu_cin, alsu_red_op_A, alsu_red_op_B;
  logic        alsu_bypass_A, alsu_bypass_B, alsu_direction, alsu_serial_in;
  logic [5:0]  alsu_out;

  logic        resp_valid, resp_ready;
  logic [5:0]  resp_data;
  logic        resp_id, resp_invalid;

  modport slave (
    input  req0_valid, req0_cmd, req1_valid, req1_cmd, alsu_out, resp_ready,
    output req0_ready, req1_ready,
    output alsu_opcode, alsu_A, alsu_B, alsu_cin, alsu_red_op_A, alsu_red_op_B,
    output alsu_bypass_A, alsu_bypass_B, alsu_direction, alsu_serial_in,
    output resp_valid, resp_data, resp_id, resp_invalid
  );

  modport master (
    output req0_valid, req0_cmd, req1_valid, req1_cmd, alsu_out, resp_ready,
    input  req0_ready, req1_ready,
    input  alsu_opcode, alsu_A, alsu_B, alsu_cin, alsu_red_op_A, alsu_red_op_B,
    input  alsu_bypass_A, alsu_bypass_B, alsu_direction, alsu_serial_in,
    input  resp_valid, resp_data, resp_id, resp_invalid
  );
endinterface

// File: rtl/alsu_arbiter.sv
// alsu_arbiter: shares one ALSU between two requesters. A granted command is
// driven to the ALSU for exactly one cycle, the ALSU latency is waited out,
// the 6-bit result is captured and returned with requester id and an
// invalid-command flag.
//   i_clk     : clock, rising edge
//   i_rst     : synchronous active-high reset
//   bus       : alsu_arbiter_if.slave (requests, ALSU drive, response)
//   o_err_cnt : saturating count of accepted invalid commands
module alsu_arbiter #(
  parameter int RR_EN    = 1,
  parameter int ALSU_LAT = 2,
  parameter int ERR_W    = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  alsu_arbiter_if.slave    bus,
  output logic [ERR_W-1:0] o_err_cnt
);

  localparam int CW = (ALSU_LAT > 1) ? $clog2(ALSU_LAT) : 1;
  localparam logic [CW-1:0] LAST = CW'(ALSU_LAT - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t           r_state, w_next;
  logic             r_last_grant;
  logic [15:0]      r_alsu_cmd;
  logic [CW-1:0]    r_wait_cnt;
  logic [5:0]       r_resp_data;
  logic             r_resp_id, r_resp_inv;
  logic [ERR_W-1:0] r_err_cnt;

  logic             w_any, w_gnt, w_hs, w_inv;
  logic [15:0]      w_cmd;
  logic             w_req0_ready, w_req1_ready;

  // Grant: single valid requester wins; on contention either alternate
  // against the last grant or give req0 fixed priority.
  always_comb begin
    w_any = bus.req0_valid | bus.req1_valid;
    if (bus.req0_valid && bus.req1_valid)
      w_gnt = (RR_EN != 0) ? ~r_last_grant : 1'b0;
    else
      w_gnt = bus.req1_valid;
    w_hs  = (r_state == IDLE) && w_any;
    w_cmd = w_gnt ? bus.req1_cmd : bus.req0_cmd;
    // Reduction only legal for AND/XOR; opcodes 6/7 are never legal.
    w_inv = ((w_cmd[5] | w_cmd[4]) & (w_cmd[14] | w_cmd[15])) |
            (w_cmd[14] & w_cmd[15]);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next       = r_state;
    w_req0_ready = 1'b0;
    w_req1_ready = 1'b0;
    case (r_state)
      IDLE: begin
        w_req0_ready = w_any & ~w_gnt;
        w_req1_ready = w_any &  w_gnt;
        if (w_any) w_next = ISSUE;
      end
      ISSUE: w_next = WAIT;
      WAIT:  if (r_wait_cnt == LAST) w_next = RESP;
      RESP:  if (bus.resp_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_last_grant <= 1'b1;
      r_alsu_cmd   <= '0;
      r_wait_cnt   <= '0;
      r_resp_data  <= '0;
      r_resp_id    <= 1'b0;
      r_resp_inv   <= 1'b0;
      r_err_cnt    <= '0;
    end else begin
      case (r_state)
        IDLE: if (w_hs) begin
          r_alsu_cmd   <= w_cmd;
          r_resp_id    <= w_gnt;
          r_resp_inv   <= w_inv;
          r_last_grant <= w_gnt;
          if (w_inv && (r_err_cnt != {ERR_W{1'b1}}))
            r_err_cnt <= r_err_cnt + ERR_W'(1);
        end
        ISSUE: begin
          // Back to the all-zero idle command so shifts start from out=0.
          r_alsu_cmd <= '0;
          r_wait_cnt <= '0;
        end
        WAIT: begin
          r_wait_cnt <= r_wait_cnt + CW'(1);
          if (r_wait_cnt == LAST) r_resp_data <= bus.alsu_out;
        end
        default: ;
      endcase
    end
  end

  assign bus.req0_ready     = w_req0_ready;
  assign bus.req1_ready     = w_req1_ready;
  assign bus.alsu_opcode    = r_alsu_cmd[15:13];
  assign bus.alsu_A         = r_alsu_cmd[12:10];
  assign bus.alsu_B         = r_alsu_cmd[9:7];
  assign bus.alsu_cin       = r_alsu_cmd[6];
  assign bus.alsu_red_op_A  = r_alsu_cmd[5];
  assign bus.alsu_red_op_B  = r_alsu_cmd[4];
  assign bus.alsu_bypass_A  = r_alsu_cmd[3];
  assign bus.alsu_bypass_B  = r_alsu_cmd[2];
  assign bus.alsu_direction = r_alsu_cmd[1];
  assign bus.alsu_serial_in = r_alsu_cmd[0];
  assign bus.resp_valid     = (r_state == RESP);
  assign bus.resp_data      = r_resp_data;
  assign bus.resp_id        = r_resp_id;
  assign bus.resp_invalid   = r_resp_inv;
  assign o_err_cnt          = r_err_cnt;

endmodule

// File: tb/tb_alsu_arbiter.sv
// tb_alsu_arbiter: directed, table-driven check of alsu_arbiter. u0/dut0 is
// round-robin with an 8-bit error counter; u1/dut1 is fixed priority with a
// 2-bit counter. A small behavioural ALSU (input reg + output reg) answers
// each arbiter.
module tb_alsu_arbiter;
  localparam int LAT = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alsu_arbiter_if u0();
  alsu_arbiter_if u1();
  logic [7:0] err0;
  logic [1:0] err1;

  alsu_arbiter #(.RR_EN(1), .ALSU_LAT(LAT), .ERR_W(8)) dut0 (
    .i_clk(clk), .i_rst(rst), .bus(u0.slave), .o_err_cnt(err0));
  alsu_arbiter #(.RR_EN(0), .ALSU_LAT(LAT), .ERR_W(2)) dut1 (
    .i_clk(clk), .i_rst(rst), .bus(u1.slave), .o_err_cnt(err1));

  logic [15:0] a0_cmd, a1_cmd, m0_in, m1_in;
  assign a0_cmd = {u0.alsu_opcode, u0.alsu_A, u0.alsu_B, u0.alsu_cin,
                   u0.alsu_red_op_A, u0.alsu_red_op_B, u0.alsu_bypass_A,
                   u0.alsu_bypass_B, u0.alsu_direction, u0.alsu_serial_in};
  assign a1_cmd = {u1.alsu_opcode, u1.alsu_A, u1.alsu_B, u1.alsu_cin,
                   u1.alsu_red_op_A, u1.alsu_red_op_B, u1.alsu_bypass_A,
                   u1.alsu_bypass_B, u1.alsu_direction, u1.alsu_serial_in};

  function automatic logic [5:0] alsu_calc(input logic [15:0] c, input logic [5:0] prev);
    logic [2:0] op;
    logic signed [5:0] sa, sb;
    logic inv;
    op  = c[15:13];
    sa  = {{3{c[12]}}, c[12:10]};
    sb  = {{3{c[9]}}, c[9:7]};
    inv = ((c[5] | c[4]) & (op[1] | op[2])) | (op[1] & op[2]);
    if (inv)  return 6'd0;
    if (c[3]) return sa;
    if (c[2]) return sb;
    case (op)
      3'd0: return c[5] ? {5'd0, &c[12:10]} : c[4] ? {5'd0, &c[9:7]} : (sa & sb);
      3'd1: return c[5] ? {5'd0, ^c[12:10]} : c[4] ? {5'd0, ^c[9:7]} : (sa ^ sb);
      3'd2: return sa + sb + {5'd0, c[6]};
      3'd3: return sa * sb;
      3'd4: return c[1] ? {prev[4:0], c[0]} : {c[0], prev[5:1]};
      3'd5: return c[1] ? {prev[4:0], prev[5]} : {prev[0], prev[5:1]};
      default: return 6'd0;
    endcase
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m0_in <= '0; m1_in <= '0; u0.alsu_out <= '0; u1.alsu_out <= '0;
    end else begin
      m0_in <= a0_cmd;
      m1_in <= a1_cmd;
      u0.alsu_out <= alsu_calc(m0_in, u0.alsu_out);
      u1.alsu_out <= alsu_calc(m1_in, u1.alsu_out);
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    u0.req0_valid = 0; u0.req1_valid = 0; u1.req0_valid = 0; u1.req1_valid = 0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Runs one command on u0; returns at the first negedge with resp_valid high.
  task automatic do_txn(input logic id, input logic [15:0] cmd, output logic [5:0] d,
                        output logic rid, output logic inv, output int lat);
    int n;
    n = 0;
    if (id) begin u0.req1_cmd = cmd; u0.req1_valid = 1'b1; end
    else    begin u0.req0_cmd = cmd; u0.req0_valid = 1'b1; end
    #1;
    while (!(id ? u0.req1_ready : u0.req0_ready) && n < 20) begin @(negedge clk); n++; end
    chk("handshake_seen", 32'(n < 20), 32'd1);
    @(negedge clk);
    u0.req0_valid = 1'b0; u0.req1_valid = 1'b0;
    chk("issue_cmd", 32'(a0_cmd), 32'(cmd));
    @(negedge clk);
    chk("idle_cmd_after_issue", 32'(a0_cmd), 32'd0);
    lat = 2;
    while (!u0.resp_valid && lat < 30) begin @(negedge clk); lat++; end
    d = u0.resp_data; rid = u0.resp_id; inv = u0.resp_invalid;
  endtask

  typedef struct {
    logic        id;
    logic [15:0] cmd;
    logic [5:0]  data;
    logic        inv;
    logic [7:0]  err;
  } vec_t;

  vec_t tv[8];

  initial begin
    logic [5:0] d, d0;
    logic rid, inv;
    int lat, n0, n1, cyc, seen1, t0, t1, nv;
    int g0[4];

    tv[0] = '{1'b0, {3'd2, 3'd3, 3'd2, 1'b1, 6'b0},        6'd6,      1'b0, 8'd0};
    tv[1] = '{1'b0, {3'd3, 3'b110, 3'd3, 7'b0},            6'b111010, 1'b0, 8'd0};
    tv[2] = '{1'b0, {3'd4, 3'd0, 3'd0, 5'b0, 1'b1, 1'b1},  6'b000001, 1'b0, 8'd0};
    tv[3] = '{1'b1, {3'd6, 13'b0},                         6'd0,      1'b1, 8'd1};
    tv[4] = '{1'b1, {3'd2, 3'd1, 3'd1, 1'b0, 1'b1, 5'b0},  6'd0,      1'b1, 8'd2};
    tv[5] = '{1'b0, {3'd2, 3'b100, 3'b111, 7'b0},          6'b111011, 1'b0, 8'd2};
    tv[6] = '{1'b1, {3'd3, 3'd3, 3'd3, 7'b0},              6'd9,      1'b0, 8'd2};
    tv[7] = '{1'b1, {3'd4, 6'b0, 5'b0, 1'b0, 1'b1},        6'b100000, 1'b0, 8'd2};

    u0.req0_cmd = '0; u0.req1_cmd = '0; u1.req0_cmd = '0; u1.req1_cmd = '0;
    u0.resp_ready = 1'b1; u1.resp_ready = 1'b1;
    do_reset();

    // Reset state
    chk("rst_alsu0", 32'(a0_cmd), 32'd0);
    chk("rst_resp0", {u0.resp_valid, u0.resp_data, u0.resp_id, u0.resp_invalid}, 32'd0);
    chk("rst_err0", 32'(err0), 32'd0);
    chk("rst_resp1_err1", {u1.resp_valid, u1.resp_data, err1, a1_cmd}, 32'd0);

    // Contention: u0 alternates, u1 always req0
    u0.req0_cmd = {3'd2, 13'b0}; u0.req1_cmd = {3'd2, 13'b0};
    u1.req0_cmd = {3'd2, 13'b0}; u1.req1_cmd = {3'd2, 13'b0};
    u0.req0_valid = 1; u0.req1_valid = 1; u1.req0_valid = 1; u1.req1_valid = 1;
    #1;
    n0 = 0; n1 = 0; cyc = 0; seen1 = 0; t0 = 0; t1 = 0;
    while (n0 < 4 && cyc < 80) begin
      if (u0.req0_ready) begin g0[n0] = 0; if (n0 == 0) t0 = cyc; if (n0 == 1) t1 = cyc; n0++; end
      else if (u0.req1_ready) begin g0[n0] = 1; if (n0 == 0) t0 = cyc; if (n0 == 1) t1 = cyc; n0++; end
      if (u1.req1_ready) seen1 = 1;
      if (u1.req0_ready && n1 < 3) n1++;
      @(negedge clk); cyc++;
    end
    u0.req0_valid = 0; u0.req1_valid = 0; u1.req0_valid = 0; u1.req1_valid = 0;
    chk("rr_grant_count", 32'(n0), 32'd4);
    for (int i = 0; i < 4; i++) chk($sformatf("rr_grant%0d", i), 32'(g0[i]), 32'(i % 2));
    chk("rr_issue_period", 32'(t1 - t0), 32'(LAT + 3));
    chk("fixed_prio_req0_grants", 32'(n1), 32'd3);
    chk("fixed_prio_req1_ready_never", 32'(seen1), 32'd0);

    // Table of single transactions on u0
    do_reset();
    foreach (tv[i]) begin
      do_txn(tv[i].id, tv[i].cmd, d, rid, inv, lat);
      chk($sformatf("v%0d_latency", i), 32'(lat), 32'(LAT + 2));
      chk($sformatf("v%0d_data", i), 32'(d), 32'(tv[i].data));
      chk($sformatf("v%0d_id", i), 32'(rid), 32'(tv[i].id));
      chk($sformatf("v%0d_inv", i), 32'(inv), 32'(tv[i].inv));
      chk($sformatf("v%0d_err", i), 32'(err0), 32'(tv[i].err));
      @(negedge clk);
      chk($sformatf("v%0d_resp_drop", i), 32'(u0.resp_valid), 32'd0);
    end

    // Saturation of the 2-bit counter on u1
    u1.req0_cmd = {3'd7, 13'b0}; u1.req0_valid = 1; #1;
    n1 = 0; cyc = 0;
    while (n1 < 5 && cyc < 100) begin
      if (u1.req0_ready) begin
        n1++;
        @(negedge clk); cyc++;
        chk($sformatf("sat_err_after_%0d", n1), 32'(err1), 32'((n1 > 3) ? 3 : n1));
      end else begin
        @(negedge clk); cyc++;
      end
    end
    u1.req0_valid = 0;
    chk("sat_txn_count", 32'(n1), 32'd5);

    // Backpressure on u0
    repeat (3) @(negedge clk);
    u0.resp_ready = 1'b0;
    do_txn(1'b0, {3'd2, 3'd1, 3'd1, 7'b0}, d0, rid, inv, lat);
    chk("bp_first_data", 32'(d0), 32'd2);
    u0.req0_valid = 1; u0.req1_valid = 1;
    nv = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (u0.resp_valid !== 1'b1 || u0.resp_data !== d0 || u0.resp_id !== 1'b0 ||
          u0.req0_ready !== 1'b0 || u0.req1_ready !== 1'b0 || a0_cmd !== 16'd0) nv++;
    end
    chk("bp_hold_violations", 32'(nv), 32'd0);
    u0.req0_valid = 0; u0.req1_valid = 0; u0.resp_ready = 1'b1;
    @(negedge clk);
    chk("bp_release", 32'(u0.resp_valid), 32'd0);

    // Reset during WAIT, then contention must go to req0
    u0.req0_cmd = {3'd2, 3'd1, 3'd2, 7'b0}; u0.req0_valid = 1; #1;
    cyc = 0;
    while (!u0.req0_ready && cyc < 20) begin @(negedge clk); cyc++; end
    @(negedge clk); u0.req0_valid = 0;   // ISSUE
    @(negedge clk);                      // WAIT
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_wait_idle", {u0.resp_valid, a0_cmd}, 32'd0);
    nv = 0;
    for (int i = 0; i < 8; i++) begin @(negedge clk); if (u0.resp_valid) nv++; end
    chk("rst_wait_no_resp", 32'(nv), 32'd0);
    u0.req0_valid = 1; u0.req1_valid = 1; #1;
    chk("rst_wait_grant_req0", {u0.req0_ready, u0.req1_ready}, 32'b10);
    @(negedge clk);
    u0.req0_valid = 0; u0.req1_valid = 0;
    repeat (6) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
